// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: data width, register count and address width.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback clears it.
// Bit 0 is never set, so x0 always reads as not busy.
module reg_file_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Set wins over clear so a newly issued producer on the same register stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        set_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/reg_file.sv
// RISC-V integer register file: two combinational read ports, one write port, x0 = 0,
// plus busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-through on reads.
module reg_file #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NUM_REGS,
    parameter int AW   = riscv_pkg::REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr
);

    import riscv_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_valid;
    logic            issue_valid;
    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;
    logic            rs1_sb_busy;
    logic            rs2_sb_busy;

    assign wr_valid    = wr_en && (wr_addr != ZERO_ADDR);
    assign issue_valid = issue_en && (issue_addr != ZERO_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_file_scoreboard #(
        .NREG(NREG),
        .AW  (AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_valid),
        .set_addr(issue_addr),
        .clr_en  (wr_valid),
        .clr_addr(wr_addr),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_busy(rs1_sb_busy),
        .rs2_busy(rs2_sb_busy)
    );

    always_comb begin
        rs1_stored = (rs1_addr == ZERO_ADDR) ? '0 : regs[rs1_addr];
        rs2_stored = (rs2_addr == ZERO_ADDR) ? '0 : regs[rs2_addr];
    end

`ifdef REGFILE_BYPASS_EN
    // A forwarded read is only busy if a new producer for that register issues this same cycle.
    always_comb begin
        rs1_data = rs1_stored;
        rs1_busy = rs1_sb_busy;
        rs2_data = rs2_stored;
        rs2_busy = rs2_sb_busy;
        if (wr_valid && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
            rs1_busy = issue_valid && (issue_addr == rs1_addr);
        end
        if (wr_valid && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
            rs2_busy = issue_valid && (issue_addr == rs2_addr);
        end
    end
`else
    assign rs1_data = rs1_stored;
    assign rs1_busy = rs1_sb_busy;
    assign rs2_data = rs2_stored;
    assign rs2_busy = rs2_sb_busy;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an array-based model of the register file.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs1_busy;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        rs2_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    logic [31:0] mdl_regs [32];
    bit          mdl_busy [32];

    reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .rs2_busy  (rs2_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_addr(issue_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: apply the write, then the issue, so a same-edge issue leaves the register busy.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                mdl_regs[i] = 32'h0;
                mdl_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                mdl_regs[wr_addr] = wr_data;
                mdl_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 5'd0) begin
                mdl_busy[issue_addr] = 1'b1;
            end
        end
    end

    function automatic logic [31:0] expData(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return mdl_regs[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return issue_en && issue_addr == a;
`endif
        return mdl_busy[a];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic applyStimulus();
        rs1_addr   = randAddr();
        rs2_addr   = ($urandom_range(0, 4) == 0) ? rs1_addr : randAddr();
        wr_en      = ($urandom_range(0, 1) == 1);
        wr_addr    = randAddr();
        wr_data    = $urandom;
        issue_en   = ($urandom_range(0, 2) == 0);
        issue_addr = randAddr();
    endtask

    always @(negedge clk) begin
        if (check_en && rst) begin
            checkOutput("cyc_rs1_data", rs1_data, expData(rs1_addr));
            checkOutput("cyc_rs2_data", rs2_data, expData(rs2_addr));
            checkOutput("cyc_rs1_busy", {31'h0, rs1_busy}, {31'h0, expBusy(rs1_addr)});
            checkOutput("cyc_rs2_busy", {31'h0, rs2_busy}, {31'h0, expBusy(rs2_addr)});
        end
    end

    initial begin
        rst = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        $display("[TB] start");

        // Everything reads zero and idle while held in reset.
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checkOutput("reset_rs1_data", rs1_data, 32'h0);
            checkOutput("reset_rs2_data", rs2_data, 32'h0);
            checkOutput("reset_rs1_busy", {31'h0, rs1_busy}, 32'h0);
            checkOutput("reset_rs2_busy", {31'h0, rs2_busy}, 32'h0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        check_en = 1'b1;

        // Write x5 and read it back on both ports.
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
`ifndef REGFILE_BYPASS_EN
        #1 checkOutput("x5_old_before_edge", rs1_data, 32'h0);
`else
        #1 checkOutput("x5_bypass_same_cycle", rs1_data, 32'hDEADBEEF);
`endif
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        checkOutput("x5_rs1", rs1_data, 32'hDEADBEEF);
        checkOutput("x5_rs2", rs2_data, 32'hDEADBEEF);

        // Writes to x0 are discarded.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        checkOutput("x0_data", rs1_data, 32'h0);
        checkOutput("x0_busy", {31'h0, rs1_busy}, 32'h0);

        // Issue marks x7 busy; writeback clears it.
        issue_en = 1'b1; issue_addr = 5'd7; rs2_addr = 5'd7;
        @(posedge clk); #1;
        issue_en = 1'b0;
        #1 checkOutput("x7_busy_after_issue", {31'h0, rs2_busy}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        checkOutput("x7_busy_after_wb", {31'h0, rs2_busy}, 32'h0);
        checkOutput("x7_data", rs2_data, 32'h12);

        // Same-edge issue and write to x9: data lands and busy stays set.
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs1_addr = 5'd9;
`ifdef REGFILE_BYPASS_EN
        #1 checkOutput("x9_bypass_data", rs1_data, 32'h55);
`endif
        @(posedge clk); #1;
        issue_en = 1'b0; wr_en = 1'b0;
        #1;
        checkOutput("x9_data", rs1_data, 32'h55);
        checkOutput("x9_busy", {31'h0, rs1_busy}, 32'h1);

        // Reset mid-cycle wipes data and busy bits, overriding pending write/issue.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        wr_en = 1'b0; rs1_addr = 5'd3;
        #1 checkOutput("x3_before_reset", rs1_data, 32'hA5A5A5A5);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1;
        issue_en = 1'b1; issue_addr = 5'd4;
        #1 rst = 1'b0;
        #1 checkOutput("x3_after_reset", rs1_data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #1;
            checkOutput("busy_after_reset", {31'h0, rs1_busy}, 32'h0);
        end
        wr_en = 1'b0; issue_en = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("x3_after_release", rs1_data, 32'h0);
        checkOutput("x4_busy_after_release", {31'h0, rs2_busy}, 32'h0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 1600; n++) begin
            @(posedge clk); #1;
            applyStimulus();
            if (n % 400 == 399) begin
                #1 rst = 1'b0;
                #1;
                checkOutput("rand_reset_data", rs1_data, 32'h0);
                checkOutput("rand_reset_busy", {31'h0, rs2_busy}, 32'h0);
                @(posedge clk); #2;
                rst = 1'b1;
            end
        end

        @(posedge clk); #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
